// File: rtl/dpram_portb_arb.sv
// Purpose : arbitrates two requesters onto the read/write port B of the core dual-port RAM.
// Latency : grant is combinational in the request cycle; read data returns exactly 1 cycle after the grant.
// Backpressure: a losing requester holds req until gnt; m0 has fixed priority, m1 is guaranteed a
//               slot after STARVE_MAX consecutive m0 grants while it waits.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_*                     core load/store requester: req/we/wem/addr/wdata in, gnt/rvalid/rdata out
//   m1_*                     debug/DMA requester, same shape as m0
//   ram_enb..ram_dinb        RAM port B command (zero when idle)
//   ram_doutb                RAM port B read data, valid the cycle after a read enable
//   stat_clr, conflict_cnt   dual-request cycle counter and its synchronous clear
//
// Build option: define DPRAM_ARB_STAT_EN to add stat_clr / conflict_cnt. Arbitration is identical
// with or without it.

module dpram_portb_arb #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [DATA_W/8-1:0] m0_wem,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [DATA_W/8-1:0] m1_wem,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              ram_enb,
   output logic              ram_web,
   output logic [DATA_W/8-1:0] ram_wemb,
   output logic [ADDR_W-1:0] ram_addrb,
   output logic [DATA_W-1:0] ram_dinb,
   input  logic [DATA_W-1:0] ram_doutb
`ifdef DPRAM_ARB_STAT_EN
   ,
   input  logic              stat_clr,
   output logic [31:0]       conflict_cnt
`endif
);

   localparam int         BE_W     = DATA_W / 8;
   localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

   // One RAM port B command, kept together so the winner mux is a single select.
   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   wem;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   cmd_t m0_cmd;
   cmd_t m1_cmd;
   cmd_t ram_cmd;

   logic [3:0] starve_q;
   logic [3:0] starve_d;
   logic       rd_pend_q;
   logic       rd_pend_d;
   logic       rd_owner_q;   // 0 = m0, 1 = m1
   logic       rd_owner_d;

   logic       m1_wins;
   logic       any_gnt;
   logic       rd_grant;

   // ---------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------
   // m1 wins when it is alone, or when m0 has used up its allotted
   // consecutive grants while m1 was waiting.
   assign m1_wins = m1_req & (~m0_req | (starve_q == STARVE_C));

   // Gating with rst keeps the RAM idle and the requesters stalled for
   // the whole time reset is asserted, not just until the first edge.
   assign m0_gnt  = ~rst & m0_req & ~m1_wins;
   assign m1_gnt  = ~rst & m1_wins;
   assign any_gnt = m0_gnt | m1_gnt;

   // ---------------------------------------------------------------
   // RAM port B drive
   // ---------------------------------------------------------------
   assign m0_cmd = '{we: m0_we, wem: m0_wem, addr: m0_addr, wdata: m0_wdata};
   assign m1_cmd = '{we: m1_we, wem: m1_wem, addr: m1_addr, wdata: m1_wdata};

   always_comb begin
      ram_cmd = '0;
      if (m0_gnt) begin
         ram_cmd = m0_cmd;
      end else if (m1_gnt) begin
         ram_cmd = m1_cmd;
      end
   end

   assign ram_enb   = any_gnt;
   assign ram_web   = ram_cmd.we;
   assign ram_wemb  = ram_cmd.wem;
   assign ram_addrb = ram_cmd.addr;
   assign ram_dinb  = ram_cmd.wdata;

   // ---------------------------------------------------------------
   // Starvation counter and read-response tracking
   // ---------------------------------------------------------------
   assign rd_grant = any_gnt & ~ram_cmd.we;

   always_comb begin
      starve_d = starve_q;
      if (m1_gnt || !m1_req) begin
         starve_d = '0;
      end else if (m0_gnt && (starve_q < STARVE_C)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // The RAM registers its read data internally, so tracking a single
   // outstanding read is enough for full 1-access/cycle throughput: a new
   // read (or a write) can be granted while the previous response is out.
   always_comb begin
      rd_pend_d  = rd_grant;
      rd_owner_d = rd_owner_q;
      if (rd_grant) begin
         rd_owner_d = m1_gnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // ---------------------------------------------------------------
   // Response steering
   // ---------------------------------------------------------------
   assign m0_rvalid = rd_pend_q & ~rd_owner_q;
   assign m1_rvalid = rd_pend_q &  rd_owner_q;
   assign m0_rdata  = m0_rvalid ? ram_doutb : '0;
   assign m1_rdata  = m1_rvalid ? ram_doutb : '0;

`ifdef DPRAM_ARB_STAT_EN
   // ---------------------------------------------------------------
   // Conflict statistics: cycles where both requesters want the port
   // ---------------------------------------------------------------
   logic        both_req;
   logic [31:0] conflict_q;
   logic [31:0] conflict_d;

   assign both_req = m0_req & m1_req;

   always_comb begin
      conflict_d = conflict_q;
      if (stat_clr) begin
         conflict_d = '0;
      end else if (both_req) begin
         conflict_d = conflict_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_q <= '0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dpram_portb_arb.sv
// Purpose : directed bench for dpram_portb_arb with a behavioural port-B RAM and a response scoreboard.
// Latency : one scoreboard entry per cycle, compared one cycle later against rvalid/rdata.
// Backpressure: requesters hold their command until the expected grant, then advance.

module tb_dpram_portb_arb;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int STARVE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m0_we;
   logic [3:0]        m0_wem;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt, m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;
   logic              m1_req, m1_we;
   logic [3:0]        m1_wem;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt, m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;
   logic              ram_enb, ram_web;
   logic [3:0]        ram_wemb;
   logic [ADDR_W-1:0] ram_addrb;
   logic [DATA_W-1:0] ram_dinb;
   logic [DATA_W-1:0] ram_doutb;
`ifdef DPRAM_ARB_STAT_EN
   logic              stat_clr;
   logic [31:0]       conflict_cnt;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v0;
      logic        v1;
      logic [31:0] d0;
      logic [31:0] d1;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] ref_mem [0:2047];
   logic [31:0] tb_mem  [0:2047];
   logic        load;
   int          ph;

   always #5 clk = ~clk;

   dpram_portb_arb #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STARVE_MAX(STARVE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_wem    (m0_wem),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_wem    (m1_wem),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .ram_enb   (ram_enb),
      .ram_web   (ram_web),
      .ram_wemb  (ram_wemb),
      .ram_addrb (ram_addrb),
      .ram_dinb  (ram_dinb),
      .ram_doutb (ram_doutb)
`ifdef DPRAM_ARB_STAT_EN
      ,
      .stat_clr     (stat_clr),
      .conflict_cnt (conflict_cnt)
`endif
   );

   function automatic logic [31:0] init_val(input int a);
      if (a == 'h010) return 32'hDEADBEEF;
      if (a == 'h020) return 32'h11223344;
      return 32'hA5000000 ^ (32'(a) * 32'h00010101);
   endfunction

   // Behavioural RAM port B: byte-masked writes, registered read data.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 2048; i++) tb_mem[i] <= init_val(i);
      end else if (ram_enb) begin
         if (ram_web) begin
            for (int b = 0; b < 4; b++)
               if (ram_wemb[b]) tb_mem[ram_addrb][8*b +: 8] <= ram_dinb[8*b +: 8];
         end else begin
            ram_doutb <= tb_mem[ram_addrb];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [3:0] wem, input logic [31:0] wd);
      for (int b = 0; b < 4; b++)
         if (wem[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
   endtask

   // Sample the current cycle: win is the expected winner (0 none, 1 m0, 2 m1).
   task automatic sample(input int win);
      resp_t r;
      resp_t nr;
      @(negedge clk);
      chk("m0_gnt", 32'(m0_gnt), 32'(win == 1));
      chk("m1_gnt", 32'(m1_gnt), 32'(win == 2));
      chk("ram_enb", 32'(ram_enb), 32'(win != 0));
      if (win == 1) chk("ram_addrb_m0", 32'(ram_addrb), 32'(m0_addr));
      if (win == 2) chk("ram_addrb_m1", 32'(ram_addrb), 32'(m1_addr));
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         r = sb.pop_front();
         chk("m0_rvalid", 32'(m0_rvalid), 32'(r.v0));
         chk("m1_rvalid", 32'(m1_rvalid), 32'(r.v1));
         if (r.v0) begin
            chk("m0_rdata", m0_rdata, r.d0);
            chk("m1_rdata_nonowner", m1_rdata, 32'd0);
         end
         if (r.v1) begin
            chk("m1_rdata", m1_rdata, r.d1);
            chk("m0_rdata_nonowner", m0_rdata, 32'd0);
         end
      end
      nr = '{1'b0, 1'b0, 32'd0, 32'd0};
      if (win == 1) begin
         if (m0_we) ref_write(m0_addr, m0_wem, m0_wdata);
         else begin nr.v0 = 1'b1; nr.d0 = ref_mem[m0_addr]; end
      end
      if (win == 2) begin
         if (m1_we) ref_write(m1_addr, m1_wem, m1_wdata);
         else begin nr.v1 = 1'b1; nr.d1 = ref_mem[m1_addr]; end
      end
      sb.push_back(nr);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   // One cycle with both requesters reading; ph counts m0 wins since m1 last won.
   task automatic both_tick();
      int win;
      win = (ph == STARVE) ? 2 : 1;
      sample(win);
      advance();
      if (win == 1) m0_addr = m0_addr + 11'd1;
      else          m1_addr = m1_addr + 11'd1;
      ph = (win == 2) ? 0 : ph + 1;
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [3:0] wem,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
      m0_req = req; m0_we = we; m0_wem = wem; m0_addr = a; m0_wdata = wd;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [3:0] wem,
                         input logic [ADDR_W-1:0] a, input logic [31:0] wd);
      m1_req = req; m1_we = we; m1_wem = wem; m1_addr = a; m1_wdata = wd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
      rst  = 1'b1;
      load = 1'b1;
      ph   = 0;
`ifdef DPRAM_ARB_STAT_EN
      stat_clr = 1'b0;
`endif
      // Requests high during reset: grants must stay gated.
      set_m0(1'b1, 1'b0, 4'h0, 11'h010, 32'd0);
      set_m1(1'b1, 1'b0, 4'h0, 11'h020, 32'd0);
      advance();
      load = 1'b0;
      @(negedge clk);
      chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
      chk("rst_ram_enb", 32'(ram_enb), 32'd0);
      chk("rst_ram_web", 32'(ram_web), 32'd0);
      advance();
      rst = 1'b0;
      set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0});

      sample(0); advance();

      // m0 single read of 0x010, then m1 write while m0 response comes back.
      set_m0(1'b1, 1'b0, 4'h0, 11'h010, 32'd0);
      sample(1); advance();
      set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      set_m1(1'b1, 1'b1, 4'b0010, 11'h020, 32'h0000AB00);
      sample(2); advance();
      set_m1(1'b1, 1'b0, 4'h0, 11'h020, 32'd0);
      sample(2); advance();
      set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      sample(0); advance();
      chk("merged_word", ref_mem[11'h020], 32'h1122AB44);

      // Alternating single-requester reads: no bubble on owner switch.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
            set_m0(1'b1, 1'b0, 4'h0, 11'h001, 32'd0);
            sample(1);
         end else begin
            set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
            set_m1(1'b1, 1'b0, 4'h0, 11'h002, 32'd0);
            sample(2);
         end
         advance();
      end
      set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      sample(0); advance();

      // Continuous dual reads: m0 x4 then m1, repeating.
      set_m0(1'b1, 1'b0, 4'h0, 11'h100, 32'd0);
      set_m1(1'b1, 1'b0, 4'h0, 11'h200, 32'd0);
      ph = 0;
      for (int i = 0; i < 15; i++) both_tick();

      // m1 dropping its request restarts m0's allowance.
      for (int i = 0; i < 3; i++) both_tick();
      m1_req = 1'b0;
      sample(1); advance();
      m0_addr = m0_addr + 11'd1;
      m1_req = 1'b1;
      ph = 0;
      for (int i = 0; i < 5; i++) both_tick();

      // Reset asserted in the cycle of a granted m0 read: response dropped.
      for (int i = 0; i < 2; i++) both_tick();
      sample(1);
      #1;
      rst = 1'b1;
      void'(sb.pop_back());
      sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0});
      #1;
      chk("rstmid_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rstmid_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rstmid_ram_enb", 32'(ram_enb), 32'd0);
      chk("rstmid_m0_rvalid", 32'(m0_rvalid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rsthold_m0_rvalid", 32'(m0_rvalid), 32'd0);
      chk("rsthold_m0_gnt", 32'(m0_gnt), 32'd0);
      advance();
      rst = 1'b0;
      ph = 0;
      for (int i = 0; i < 5; i++) both_tick();

      set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
`ifdef DPRAM_ARB_STAT_EN
      stat_clr = 1'b1;
      sample(0); advance();
      stat_clr = 1'b0;
      chk("conflict_cleared", conflict_cnt, 32'd0);
      set_m0(1'b1, 1'b0, 4'h0, 11'h300, 32'd0);
      set_m1(1'b1, 1'b0, 4'h0, 11'h400, 32'd0);
      ph = 0;
      for (int i = 0; i < 7; i++) both_tick();
      chk("conflict_7", conflict_cnt, 32'd7);
      stat_clr = 1'b1;
      both_tick();
      stat_clr = 1'b0;
      chk("conflict_clr_wins", conflict_cnt, 32'd0);
      set_m0(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
      set_m1(1'b0, 1'b0, 4'h0, 11'h000, 32'd0);
`endif
      sample(0); advance();
      sample(0); advance();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
